cmp_flags_arbiter: RTL and testbench

//  Shares the single N-bit Compare datapath between two requesters: 0 = execute-stage CMP, 1 = microcode/debug port.

---
 rtl/cmp_pkg.sv | 33 +++
 rtl/Compare.sv | 29 ++
 rtl/cmp_flags_arbiter_cond_eval.sv | 40 ++++
 rtl/cmp_flags_arbiter.sv | 103 ++++++++++
 tb/tb_cmp_flags_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the compare/flags arbiter slice: FSM states,
// NZCV bit positions and ARM condition-code values.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/Compare.sv
// N-bit compare datapath: computes a-b and reports the NZCV flags of the result.
module Compare
  import cmp_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] in1_i,
  input  logic [N-1:0] in2_i,
  output logic [3:0]   nzcv_o
);

  logic [N:0]   diff_ext;
  logic [N-1:0] diff;
  logic         borrow;

  // The extra MSB of the widened subtraction is the borrow out; carry is its inverse.
  assign diff_ext = {1'b0, in1_i} - {1'b0, in2_i};
  assign diff     = diff_ext[N-1:0];
  assign borrow   = diff_ext[N];

  always_comb begin
    nzcv_o         = '0;
    nzcv_o[FLAG_N] = diff[N-1];
    nzcv_o[FLAG_Z] = (diff == '0);
    nzcv_o[FLAG_C] = ~borrow;
    nzcv_o[FLAG_V] = (in1_i[N-1] != in2_i[N-1]) && (diff[N-1] != in1_i[N-1]);
  end

endmodule

// File: rtl/cmp_flags_arbiter_cond_eval.sv
// ARM condition-code evaluation against an NZCV flag set.
module cond_eval
  import cmp_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_flags_arbiter.sv
// Round-robin sharing of the Compare datapath between execute CMP (0) and the
// microcode/debug port (1); latches NZCV and evaluates condition codes on it.
module cmp_flags_arbiter
  import cmp_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [3:0]   rsp_flags,
  output logic [3:0]   flags,
  output logic         busy,
  input  logic [3:0]   cond,
  output logic         cond_pass
);

  state_t       state_q;
  logic         last_grant_q;
  logic [N-1:0] a_q, b_q;
  logic         id_q;
  logic [3:0]   rsp_flags_q;
  logic [3:0]   flags_q;

  logic         grant_id;
  logic         accept;
  logic [N-1:0] sel_a, sel_b;
  logic [3:0]   cmp_nzcv;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  always_comb begin
    grant_id  = (&req_valid) ? ~last_grant_q : req_valid[1];
    req_ready = '0;
    if ((state_q == ST_IDLE) && (|req_valid)) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
    accept = |(req_valid & req_ready);
    sel_a  = grant_id ? req1_a : req0_a;
    sel_b  = grant_id ? req1_b : req0_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q          <= sel_a;
            b_q          <= sel_b;
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_flags_q <= cmp_nzcv;
          flags_q     <= cmp_nzcv;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = id_q;
  assign rsp_flags = rsp_flags_q;
  assign flags     = flags_q;

  Compare #(.N(N)) u_compare (
    .in1_i  (a_q),
    .in2_i  (b_q),
    .nzcv_o (cmp_nzcv)
  );

  cond_eval u_cond_eval (
    .cond_i  (cond),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

endmodule

// File: tb/tb_cmp_flags_arbiter.sv
// Self-checking bench for cmp_flags_arbiter: vector table, randomized compares
// against an arithmetic reference, and hand-written arbitration/reset sequences.
`timescale 1ns/100ps
module tb_cmp_flags_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [3:0]   rsp_flags;
  logic [3:0]   flags;
  logic         busy;
  logic [3:0]   cond;
  logic         cond_pass;

  always #5 clk = ~clk;

  cmp_flags_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_flags (rsp_flags),
    .flags     (flags),
    .busy      (busy),
    .cond      (cond),
    .cond_pass (cond_pass)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit           id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference flags from integer arithmetic: signed overflow is detected by range.
  function automatic logic [3:0] model_nzcv(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] d;
    longint       sd;
    longint       smax;
    longint       smin;
    logic         v;
    d    = a - b;
    sd   = longint'($signed(a)) - longint'($signed(b));
    smax = (longint'(1) <<< (N-1)) - 1;
    smin = -(longint'(1) <<< (N-1));
    v    = (sd > smax) || (sd < smin);
    return {d[N-1], a == b, a >= b, v};
  endfunction

  // Condition outcome from the operands themselves rather than from flag bits.
  function automatic logic cond_model(input logic [3:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [3:0] f;
    logic       sge;
    f   = model_nzcv(a, b);
    sge = ($signed(a) >= $signed(b));
    case (c)
      4'h0: return a == b;
      4'h1: return a != b;
      4'h2: return a >= b;
      4'h3: return a < b;
      4'h4: return f[3];
      4'h5: return !f[3];
      4'h6: return f[0];
      4'h7: return !f[0];
      4'h8: return a > b;
      4'h9: return a <= b;
      4'hA: return sge;
      4'hB: return !sge;
      4'hC: return $signed(a) > $signed(b);
      4'hD: return $signed(a) <= $signed(b);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Raise one request and return in the EXEC cycle (one tick after the accept edge).
  task automatic issue(input bit id, input logic [N-1:0] a, input logic [N-1:0] b, output bit ok);
    logic [1:0] want;
    want = id ? 2'b10 : 2'b01;
    if (id) begin
      req1_a = a;
      req1_b = b;
    end else begin
      req0_a = a;
      req0_b = b;
    end
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (req_ready == want) ok = 1'b1;
      else tick();
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("accept_timeout", 0, 1);
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic run_one(input string tag, input bit id, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [3:0] exp);
    bit ok;
    issue(id, a, b, ok);
    if (!ok) return;
    check({tag, "_exec_busy"}, busy, 1);
    check({tag, "_exec_rsp_valid"}, rsp_valid, 0);
    tick();
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_id"}, rsp_id, id);
    check({tag, "_rsp_flags"}, rsp_flags, exp);
    check({tag, "_flags"}, flags, exp);
    check({tag, "_resp_req_ready"}, req_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_done_rsp_valid"}, rsp_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c);
      #1;
      check($sformatf("%s_cond%0h", tag, c), cond_pass, cond_model(4'(c), a, b));
    end
  endtask

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return N'($urandom_range(0, 15));
      default: return N'($urandom());
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         gcyc[$];
    int         gid[$];
    int         rid[$];
    logic [15:0] reset_mask;
    bit         ok;
    logic [N-1:0] ra, rb;
    bit         rid_bit;

    vecs[0] = '{0, 32'd7,          32'd4,          4'b0010};
    vecs[1] = '{1, 32'd4,          32'd7,          4'b1000};
    vecs[2] = '{0, 32'h8000_0000,  32'd1,          4'b0011};
    vecs[3] = '{0, 32'd5,          32'd5,          4'b0110};
    vecs[4] = '{1, 32'd0,          32'hFFFF_FFFF,  4'b0000};
    vecs[5] = '{0, 32'hFFFF_FFFF,  32'd0,          4'b1010};
    vecs[6] = '{1, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  4'b1001};
    vecs[7] = '{0, 32'd0,          32'h8000_0000,  4'b1001};

    rst_n = 1'b0;
    req_valid = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    cond = 4'h0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Flags 0000 after reset: expected pass bit per condition code.
    reset_mask = 16'h56AA;
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c);
      #1;
      check($sformatf("rst_cond%0h", c), cond_pass, reset_mask[c]);
    end

    for (int i = 0; i < 8; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    for (int i = 0; i < 24; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      rid_bit = 1'($urandom_range(0, 1));
      run_one($sformatf("rnd%0d", i), rid_bit, ra, rb, model_nzcv(ra, rb));
    end

    // Both requesters held valid from reset: grants alternate starting with 0.
    apply_reset();
    req0_a = 32'd7; req0_b = 32'd4;
    req1_a = 32'd4; req1_b = 32'd7;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        gcyc.push_back(cyc);
        gid.push_back(int'(req_ready[1]));
      end
      if (rsp_valid) rid.push_back(int'(rsp_id));
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    check("rr_grant_count", gid.size(), 4);
    check("rr_rsp_count", rid.size(), 4);
    for (int i = 0; i < 4 && i < gid.size() && i < rid.size(); i++) begin
      check($sformatf("rr_grant%0d_id", i), gid[i], i % 2);
      check($sformatf("rr_grant%0d_cycle", i), gcyc[i], 3 * i);
      check($sformatf("rr_rsp%0d_id", i), rid[i], i % 2);
    end

    // Backpressure: RESP held 5 cycles while requester 1 waits.
    issue(0, 32'd9, 32'd3, ok);
    req1_a = 32'd2; req1_b = 32'd2;
    req_valid[1] = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_rsp_valid", k), rsp_valid, 1);
      check($sformatf("bp%0d_rsp_id", k), rsp_id, 0);
      check($sformatf("bp%0d_rsp_flags", k), rsp_flags, model_nzcv(32'd9, 32'd3));
      check($sformatf("bp%0d_req_ready", k), req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_rsp_valid", rsp_valid, 0);
    check("bp_idle_req_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check("bp_next_exec_busy", busy, 1);
    check("bp_next_rsp_valid", rsp_valid, 0);
    tick();
    check("bp_next_rsp_valid2", rsp_valid, 1);
    check("bp_next_rsp_id", rsp_id, 1);
    check("bp_next_rsp_flags", rsp_flags, model_nzcv(32'd2, 32'd2));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_end_rsp_valid", rsp_valid, 0);

    // A request withdrawn before any edge is neither accepted nor counted for fairness.
    req0_a = 32'd7; req0_b = 32'd4;
    req_valid[0] = 1'b1;
    #1;
    check("drop_req_ready", req_ready, 2'b01);
    #1;
    req_valid[0] = 1'b0;
    tick();
    check("drop_busy", busy, 0);
    req_valid = 2'b11;
    #1;
    check("drop_then_both_grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    check("drop_rsp_id", rsp_id, 0);
    check("drop_rsp_flags", rsp_flags, 4'b0010);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Asynchronous reset landing in EXEC aborts the compare.
    issue(1, 32'd4, 32'd7, ok);
    #1;
    rst_n = 1'b0;
    #1;
    check("rx_rsp_valid", rsp_valid, 0);
    check("rx_busy", busy, 0);
    check("rx_flags", flags, 0);
    check("rx_rsp_flags", rsp_flags, 0);
    check("rx_req_ready", req_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rx_after%0d_rsp_valid", k), rsp_valid, 0);
      check($sformatf("rx_after%0d_flags", k), flags, 0);
    end
    run_one("rx_next", 1, 32'd4, 32'd7, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
